// File: rtl/room_allocator_pkg.sv
// Shared definitions for the three-room allocator: FSM encoding, room indices,
// default sizing and a room-index decode helper.
package room_allocator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [1:0] ROOM_NONE = 2'd0;
  localparam logic [1:0] ROOM1     = 2'd1;
  localparam logic [1:0] ROOM2     = 2'd2;
  localparam logic [1:0] ROOM3     = 2'd3;

  localparam int MAX_OCC_DEFAULT = 7;
  localparam int CW_DEFAULT      = 3;

  function automatic logic [2:0] room_onehot(input logic [1:0] room);
    case (room)
      ROOM1:   room_onehot = 3'b001;
      ROOM2:   room_onehot = 3'b010;
      ROOM3:   room_onehot = 3'b100;
      default: room_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/room_min_select.sv
// Combinational helper: lowest-index least-occupied room (0 when every room is
// full) and the max-min spread of the three counts.
module room_min_select
  import room_allocator_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic [CW-1:0] count1,
  input  logic [CW-1:0] count2,
  input  logic [CW-1:0] count3,
  input  logic [CW-1:0] max_occ,
  output logic [1:0]    room,
  output logic [CW-1:0] spread
);

  logic [CW-1:0] min12_s, min_s, max12_s, max_s;
  logic [1:0]    room12_s, room_min_s;
  logic          all_full_s;

  // Strict less-than keeps ties on the lower-numbered room.
  assign min12_s    = (count2 < count1) ? count2 : count1;
  assign room12_s   = (count2 < count1) ? ROOM2 : ROOM1;
  assign min_s      = (count3 < min12_s) ? count3 : min12_s;
  assign room_min_s = (count3 < min12_s) ? ROOM3 : room12_s;

  assign max12_s    = (count2 > count1) ? count2 : count1;
  assign max_s      = (count3 > max12_s) ? count3 : max12_s;

  assign all_full_s = (count1 == max_occ) && (count2 == max_occ) && (count3 == max_occ);
  assign room       = all_full_s ? ROOM_NONE : room_min_s;
  assign spread     = max_s - min_s;

endmodule

// File: rtl/room_allocator.sv
// Assigns each entry request to the least-occupied of three rooms, tracks
// per-room occupancy with exit pulses and flags occupancy imbalance.
module room_allocator
  import room_allocator_pkg::*;
#(
  parameter int MAX_OCC = MAX_OCC_DEFAULT,
  parameter int CW      = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enter,
  input  logic [2:0]    leave,
  output logic [CW-1:0] C1,
  output logic [CW-1:0] C2,
  output logic [CW-1:0] C3,
  output logic          grant,
  output logic [1:0]    grant_room,
  output logic          reject,
  output logic          imbalance,
  output logic          busy
);

  state_t        state_r;
  logic          busy_r, pending_r, grant_r, reject_r, imbalance_r;
  logic [1:0]    grant_room_r, best_room_r, next_room_s;
  logic [CW-1:0] count_r [3];
  logic [CW-1:0] count_next_s [3];
  logic [CW-1:0] spread_s;
  logic [2:0]    inc_s;

  // A granted room increments during the GRANT cycle, which is exactly when grant_r is high.
  assign inc_s = grant_r ? room_onehot(grant_room_r) : 3'b000;

  // Next occupancy: increment and leave on the same room cancel; leave at zero is ignored.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (inc_s[i] && leave[i]) begin
        count_next_s[i] = count_r[i];
      end else if (inc_s[i]) begin
        count_next_s[i] = count_r[i] + CW'(1);
      end else if (leave[i] && (count_r[i] != '0)) begin
        count_next_s[i] = count_r[i] - CW'(1);
      end else begin
        count_next_s[i] = count_r[i];
      end
    end
  end

  // Evaluated on next-state counts so that, registered, best_room_r reflects the
  // counts held during PICK (leaves arriving in PICK are not seen by the pick).
  room_min_select #(.CW(CW)) u_min_select (
    .count1  (count_next_s[0]),
    .count2  (count_next_s[1]),
    .count3  (count_next_s[2]),
    .max_occ (CW'(MAX_OCC)),
    .room    (next_room_s),
    .spread  (spread_s)
  );

  // Occupancy counters, registered best room and imbalance flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) count_r[i] <= '0;
      best_room_r <= ROOM1;
      imbalance_r <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) count_r[i] <= count_next_s[i];
      best_room_r <= next_room_s;
      imbalance_r <= (spread_s >= CW'(2));
    end
  end

  // Request FSM with one-deep pending slot and registered pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      pending_r    <= 1'b0;
      grant_r      <= 1'b0;
      reject_r     <= 1'b0;
      grant_room_r <= ROOM_NONE;
    end else begin
      grant_r  <= 1'b0;
      reject_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enter || pending_r) begin
            state_r   <= PICK;
            busy_r    <= 1'b1;
            pending_r <= pending_r & enter;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        PICK: begin
          state_r <= GRANT;
          busy_r  <= 1'b1;
          if (best_room_r != ROOM_NONE) begin
            grant_r      <= 1'b1;
            grant_room_r <= best_room_r;
          end else begin
            reject_r <= 1'b1;
          end
        end
        GRANT: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if ((state_r != IDLE) && enter) begin
        if (pending_r) begin
          reject_r <= 1'b1;
        end else begin
          pending_r <= 1'b1;
        end
      end
    end
  end

  assign C1         = count_r[0];
  assign C2         = count_r[1];
  assign C3         = count_r[2];
  assign grant      = grant_r;
  assign grant_room = grant_room_r;
  assign reject     = reject_r;
  assign imbalance  = imbalance_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_room_allocator.sv
// Self-checking bench for room_allocator: directed scenarios plus randomized
// traffic checked against a cycle-scheduled behavioural model.
module tb_room_allocator;

  localparam int CW      = 3;
  localparam int MAX_OCC = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enter = 1'b0;
  logic [2:0]    leave = 3'b000;
  logic [CW-1:0] C1, C2, C3;
  logic          grant, reject, imbalance, busy;
  logic [1:0]    grant_room;

  int n_checks = 0;
  int n_fail   = 0;

  room_allocator #(.MAX_OCC(MAX_OCC), .CW(CW)) dut (
    .clock(clock), .reset(reset), .enter(enter), .leave(leave),
    .C1(C1), .C2(C2), .C3(C3), .grant(grant), .grant_room(grant_room),
    .reject(reject), .imbalance(imbalance), .busy(busy)
  );

  always #5 clock = ~clock;

  // Model: outputs expected in the current cycle plus scheduled events by cycle number.
  int cyc = 0;
  int m_c[3];
  int m_room, m_tgt, pick_at, grant_at, idle_at;
  bit m_grant, m_reject, m_imb, m_busy, m_pending;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_c[i] = 0;
    m_room = 0; m_tgt = 0; pick_at = -1; grant_at = -1; idle_at = 0;
    m_grant = 0; m_reject = 0; m_imb = 0; m_busy = 0; m_pending = 0;
  endtask

  function automatic int least_room();
    int best;
    if (m_c[0] == MAX_OCC && m_c[1] == MAX_OCC && m_c[2] == MAX_OCC) return 0;
    best = 0;
    for (int i = 1; i < 3; i++) if (m_c[i] < m_c[best]) best = i;
    return best + 1;
  endfunction

  task automatic model_cycle(input bit e, input bit [2:0] l);
    int nc[3];
    int mx, mn;
    bit ng, nr, busy_now;
    ng = 0; nr = 0;
    busy_now = (cyc < idle_at);
    if (cyc == pick_at) begin
      m_tgt = least_room();
      ng = (m_tgt != 0);
      nr = (m_tgt == 0);
      grant_at = cyc + 1;
    end
    if (!busy_now) begin
      if (e || m_pending) begin
        pick_at = cyc + 1;
        idle_at = cyc + 3;
        m_pending = m_pending && e;
      end
    end else if (e) begin
      if (m_pending) nr = 1;
      else m_pending = 1;
    end
    for (int i = 0; i < 3; i++) begin
      bit inc;
      inc = (cyc == grant_at) && (m_tgt == i + 1);
      if (inc && l[i]) nc[i] = m_c[i];
      else if (inc) nc[i] = m_c[i] + 1;
      else if (l[i] && m_c[i] > 0) nc[i] = m_c[i] - 1;
      else nc[i] = m_c[i];
    end
    mx = nc[0]; mn = nc[0];
    for (int i = 1; i < 3; i++) begin
      if (nc[i] > mx) mx = nc[i];
      if (nc[i] < mn) mn = nc[i];
    end
    for (int i = 0; i < 3; i++) m_c[i] = nc[i];
    m_imb = (mx - mn) >= 2;
    m_grant = ng;
    m_reject = nr;
    if (ng) m_room = m_tgt;
    cyc++;
    m_busy = (cyc < idle_at);
  endtask

  task automatic step(input bit e, input bit [2:0] l);
    enter = e; leave = l;
    model_cycle(e, l);
    @(posedge clock); #1;
    enter = 1'b0; leave = 3'b000;
  endtask

  function automatic logic [14:0] exp_vec();
    return {CW'(m_c[0]), CW'(m_c[1]), CW'(m_c[2]), m_grant, 2'(m_room), m_reject, m_imb, m_busy};
  endfunction

  function automatic logic [14:0] got_vec();
    return {C1, C2, C3, grant, grant_room, reject, imbalance, busy};
  endfunction

  task automatic do_reset();
    reset = 1'b1; enter = 1'b0; leave = 3'b000;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (got_vec() !== 15'd0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=0000", got_vec());
    end
    reset = 1'b0;
    model_reset();
    cyc++;
  endtask

  task automatic test_single_enter();
    step(1'b1, 3'b000);
    n_checks++;
    if ({grant, reject, busy} !== 3'b001) begin
      n_fail++; $display("FAIL single_pick got=%b exp=001", {grant, reject, busy});
    end
    step(1'b0, 3'b000);
    n_checks++;
    if ({grant, grant_room, C1} !== {1'b1, 2'd1, 3'd0}) begin
      n_fail++; $display("FAIL single_grant got=%b exp=%b", {grant, grant_room, C1}, {1'b1, 2'd1, 3'd0});
    end
    step(1'b0, 3'b000);
    n_checks++;
    if ({C1, C2, C3, imbalance, busy, grant} !== {3'd1, 3'd0, 3'd0, 3'b000}) begin
      n_fail++; $display("FAIL single_after got=%b exp=%b", {C1, C2, C3, imbalance, busy, grant}, {3'd1, 3'd0, 3'd0, 3'b000});
    end
  endtask

  task automatic test_sequence();
    logic [1:0] rooms [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rooms[k] = 2'd0;
      step(1'b1, 3'b000);
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 3'b000);
        if (grant) rooms[k] = grant_room;
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rooms[k] !== 2'(k + 1)) begin
        n_fail++; $display("FAIL seq_room%0d got=%0d exp=%0d", k, rooms[k], k + 1);
      end
    end
    n_checks++;
    if ({C1, C2, C3} !== {3'd1, 3'd1, 3'd1}) begin
      n_fail++; $display("FAIL seq_counts got=%0d/%0d/%0d exp=1/1/1", C1, C2, C3);
    end
  endtask

  task automatic test_leave();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 3'b000);
      for (int j = 0; j < 3; j++) step(1'b0, 3'b000);
    end
    step(1'b0, 3'b110);
    step(1'b0, 3'b110);
    n_checks++;
    if ({C1, C2, C3} !== {3'd3, 3'd1, 3'd1}) begin
      n_fail++; $display("FAIL leave_preload got=%0d/%0d/%0d exp=3/1/1", C1, C2, C3);
    end
    step(1'b0, 3'b010);
    n_checks++;
    if (C2 !== 3'd0) begin
      n_fail++; $display("FAIL leave_first got=%0d exp=0", C2);
    end
    step(1'b0, 3'b010);
    n_checks++;
    if (C2 !== 3'd0) begin
      n_fail++; $display("FAIL leave_underflow got=%0d exp=0", C2);
    end
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    n_checks++;
    if (imbalance !== 1'b1 || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL leave_imbalance got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_saturate();
    int grants;
    do_reset();
    grants = 0;
    for (int k = 0; k < 21; k++) begin
      step(1'b1, 3'b000);
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 3'b000);
        if (grant) grants++;
      end
    end
    n_checks++;
    if (grants != 21 || {C1, C2, C3} !== {3'd7, 3'd7, 3'd7}) begin
      n_fail++; $display("FAIL sat_fill got=%0d grants %0d/%0d/%0d exp=21 grants 7/7/7", grants, C1, C2, C3);
    end
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    n_checks++;
    if ({reject, grant, grant_room} !== {1'b1, 1'b0, 2'd3}) begin
      n_fail++; $display("FAIL sat_reject got=%b exp=%b", {reject, grant, grant_room}, {1'b1, 1'b0, 2'd3});
    end
    step(1'b0, 3'b000);
    n_checks++;
    if ({C1, C2, C3, reject} !== {3'd7, 3'd7, 3'd7, 1'b0}) begin
      n_fail++; $display("FAIL sat_hold got=%0d/%0d/%0d rej=%b exp=7/7/7 rej=0", C1, C2, C3, reject);
    end
  endtask

  task automatic test_back_to_back();
    int grants;
    do_reset();
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    n_checks++;
    if ({grant, grant_room} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL b2b_first got=%b exp=101", {grant, grant_room});
    end
    grants = 1;
    step(1'b1, 3'b000);
    n_checks++;
    if ({reject, grant} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_overflow got=%b exp=10", {reject, grant});
    end
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    n_checks++;
    if ({grant, grant_room, reject} !== {1'b1, 2'd2, 1'b0}) begin
      n_fail++; $display("FAIL b2b_pending got=%b exp=1100", {grant, grant_room, reject});
    end
    grants++;
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 3'b000);
      if (grant) grants++;
    end
    n_checks++;
    if (grants != 2 || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_total got=%0d grants vec=%h exp=2 grants vec=%h", grants, got_vec(), exp_vec());
    end
  endtask

  task automatic test_net_zero();
    do_reset();
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    step(1'b0, 3'b001);
    n_checks++;
    if ({C1, grant_room} !== {3'd0, 2'd1} || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL net_zero got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 3'b000);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (got_vec() !== 15'd0) begin
      n_fail++; $display("FAIL reset_mid_async got=%h exp=0000", got_vec());
    end
    @(posedge clock); #1;
    n_checks++;
    if ({grant, busy, grant_room} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_nogrant got=%b exp=0000", {grant, busy, grant_room});
    end
    reset = 1'b0;
    model_reset();
    cyc++;
    test_single_enter();
  endtask

  task automatic test_random();
    bit e;
    bit [2:0] l;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i < 300) begin
        e = ($urandom_range(0, 1) == 0);
        for (int b = 0; b < 3; b++) l[b] = ($urandom_range(0, 19) == 0);
      end else begin
        e = ($urandom_range(0, 2) == 0);
        for (int b = 0; b < 3; b++) l[b] = ($urandom_range(0, 4) == 0);
      end
      step(e, l);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_enter();
    test_sequence();
    test_leave();
    test_saturate();
    test_back_to_back();
    test_net_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
